// File: rtl/aes_engine_stream_adapter_if.sv
// Bundle of controller, plaintext/ciphertext stream and AES core signals for the stream adapter.
// Handshake rule for every valid/ready pair: a transfer happens on a clk edge where both are high;
// once valid rises, valid and its data stay unchanged until that transfer.
interface aes_engine_stream_adapter_if #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
);
    logic               clear_i;
    logic               enable_i;
    logic               start_i;
    logic [CNT_W-1:0]   nblocks_i;
    logic [DATA_W-1:0]  in_data_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [BLOCK_W-1:0] core_pt_o;
    logic               core_valid_o;
    logic               core_ready_i;
    logic [BLOCK_W-1:0] core_ct_i;
    logic               core_ct_valid_i;
    logic               core_ct_ready_o;
    logic [DATA_W-1:0]  out_data_o;
    logic               out_valid_o;
    logic               out_ready_i;
    logic               busy_o;
    logic               done_o;
    logic [CNT_W-1:0]   blk_cnt_o;
    logic [2:0]         dbg_state;

    modport master (
        output clear_i, enable_i, start_i, nblocks_i, in_data_i, in_valid_i,
               core_ready_i, core_ct_i, core_ct_valid_i, out_ready_i,
        input  in_ready_o, core_pt_o, core_valid_o, core_ct_ready_o, out_data_o,
               out_valid_o, busy_o, done_o, blk_cnt_o, dbg_state
    );

    modport slave (
        input  clear_i, enable_i, start_i, nblocks_i, in_data_i, in_valid_i,
               core_ready_i, core_ct_i, core_ct_valid_i, out_ready_i,
        output in_ready_o, core_pt_o, core_valid_o, core_ct_ready_o, out_data_o,
               out_valid_o, busy_o, done_o, blk_cnt_o, dbg_state
    );
endinterface

// File: rtl/aes_engine_stream_adapter.sv
// Packs 32-bit plaintext words into AES blocks, unpacks ciphertext blocks into words,
// and answers the controller's start/clear/enable handshake with busy/done/block count.
module aes_engine_stream_adapter #(
    parameter int DATA_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic reset_n,
    aes_engine_stream_adapter_if.slave bus
);
    localparam int WORDS = BLOCK_W / DATA_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t                        state;
    logic [IDX_W-1:0]              widx;
    logic [WORDS-1:0][DATA_W-1:0]  pt_q;
    logic [WORDS-1:0][DATA_W-1:0]  ct_q;
    logic [CNT_W-1:0]              nblocks_q;
    logic [CNT_W-1:0]              blk_cnt;
    logic                          core_valid_q;
    logic                          out_valid_q;
    logic                          done_q;
    logic                          busy_q;
    logic [CNT_W:0]                cnt_inc;
    logic                          last_blk;

    // One extra bit so the final-block compare is exact even at the top count.
    assign cnt_inc  = {1'b0, blk_cnt} + (CNT_W+1)'(1);
    assign last_blk = (cnt_inc == {1'b0, nblocks_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            widx         <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            nblocks_q    <= '0;
            blk_cnt      <= '0;
            core_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.clear_i) begin
            state        <= ST_IDLE;
            widx         <= '0;
            pt_q         <= '0;
            ct_q         <= '0;
            nblocks_q    <= '0;
            blk_cnt      <= '0;
            core_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else if (bus.enable_i) begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        nblocks_q <= bus.nblocks_i;
                        blk_cnt   <= '0;
                        widx      <= '0;
                        busy_q    <= 1'b1;
                        if (bus.nblocks_i == '0) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid_i) begin
                        pt_q[widx] <= bus.in_data_i;
                        widx       <= widx + IDX_W'(1);
                        if (widx == LAST_IDX) begin
                            state        <= ST_ISSUE;
                            core_valid_q <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.core_ready_i) begin
                        state        <= ST_WAIT;
                        core_valid_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (bus.core_ct_valid_i) begin
                        ct_q        <= bus.core_ct_i;
                        state       <= ST_DRAIN;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.out_ready_i) begin
                        widx <= widx + IDX_W'(1);
                        if (widx == LAST_IDX) begin
                            out_valid_q <= 1'b0;
                            if (blk_cnt != {CNT_W{1'b1}}) begin
                                blk_cnt <= cnt_inc[CNT_W-1:0];
                            end
                            if (last_blk) begin
                                state  <= ST_DONE;
                                done_q <= 1'b1;
                            end else begin
                                state <= ST_LOAD;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Readies are gated by enable so a frozen engine never completes a transfer.
    assign bus.in_ready_o      = (state == ST_LOAD) && bus.enable_i;
    assign bus.core_ct_ready_o = (state == ST_WAIT) && bus.enable_i;
    assign bus.core_pt_o       = pt_q;
    assign bus.core_valid_o    = core_valid_q;
    assign bus.out_data_o      = ct_q[widx];
    assign bus.out_valid_o     = out_valid_q;
    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
    assign bus.blk_cnt_o       = blk_cnt;
    assign bus.dbg_state       = state;
endmodule

// File: tb/tb_aes_engine_stream_adapter.sv
// Directed bench for the AES stream adapter: source/sink/core models plus a scoreboard monitor.
module tb_aes_engine_stream_adapter;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic clk;
    logic reset_n;

    aes_engine_stream_adapter_if #(.DATA_W(32), .BLOCK_W(128), .CNT_W(16)) bus ();

    aes_engine_stream_adapter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0]  src_q[$];
    logic [127:0] ct_src_q[$];
    logic [127:0] exp_pt_q[$];
    logic [31:0]  exp_out_q[$];
    logic [15:0]  exp_done_q[$];

    bit in_fire, pt_fire, ct_fire, out_fire;
    bit rand_bp = 0;
    bit flush = 0;
    int core_lat = 1;
    int in_cnt = 0;
    int out_cnt = 0;
    int done_cnt = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_msg(input string name);
        total++;
        bad++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    // plaintext source
    initial begin
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        forever begin
            @(posedge clk); #1;
            if (flush) begin
                bus.in_valid_i = 1'b0;
                src_q.delete();
            end else begin
                if (in_fire) begin
                    bus.in_valid_i = 1'b0;
                    void'(src_q.pop_front());
                end
                if (!bus.in_valid_i && src_q.size() > 0 && (!rand_bp || $urandom_range(0, 1) == 1)) begin
                    bus.in_valid_i = 1'b1;
                    bus.in_data_i  = src_q[0];
                end
            end
        end
    end

    // ciphertext sink
    initial begin
        bus.out_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // AES core model: returns queued ciphertexts in order after core_lat cycles
    initial begin
        bit pending;
        int delay;
        pending = 0;
        delay = 0;
        bus.core_ready_i    = 1'b0;
        bus.core_ct_valid_i = 1'b0;
        bus.core_ct_i       = '0;
        forever begin
            @(posedge clk); #1;
            if (flush) begin
                bus.core_ct_valid_i = 1'b0;
                pending = 0;
            end else begin
                if (ct_fire) bus.core_ct_valid_i = 1'b0;
                if (pt_fire) begin
                    pending = 1;
                    delay = core_lat;
                end
                if (pending && !bus.core_ct_valid_i) begin
                    if (delay == 0) begin
                        bus.core_ct_valid_i = 1'b1;
                        bus.core_ct_i = (ct_src_q.size() > 0) ? ct_src_q.pop_front() : '0;
                        pending = 0;
                    end else begin
                        delay--;
                    end
                end
            end
            bus.core_ready_i = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // monitor / scoreboard
    initial begin
        bit          out_hold;
        logic [31:0] hold_data;
        out_hold = 0;
        hold_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_fire = 0; pt_fire = 0; ct_fire = 0; out_fire = 0; out_hold = 0;
            end else begin
                in_fire  = bus.in_valid_i && bus.in_ready_o && !bus.clear_i;
                pt_fire  = bus.core_valid_o && bus.core_ready_i && bus.enable_i && !bus.clear_i;
                ct_fire  = bus.core_ct_valid_i && bus.core_ct_ready_o && !bus.clear_i;
                out_fire = bus.out_valid_o && bus.out_ready_i && bus.enable_i && !bus.clear_i;
                if (out_hold) begin
                    chk("out_valid_held", 128'(bus.out_valid_o), 128'(1));
                    chk("out_data_held", 128'(bus.out_data_o), 128'(hold_data));
                end
                if (in_fire) in_cnt++;
                if (pt_fire) begin
                    if (exp_pt_q.size() == 0) fail_msg("pt_unexpected");
                    else chk("core_pt", bus.core_pt_o, exp_pt_q.pop_front());
                end
                if (out_fire) begin
                    out_cnt++;
                    if (exp_out_q.size() == 0) fail_msg("out_unexpected");
                    else chk("out_word", 128'(bus.out_data_o), 128'(exp_out_q.pop_front()));
                end
                if (bus.done_o) begin
                    done_cnt++;
                    if (exp_done_q.size() == 0) fail_msg("done_unexpected");
                    else begin
                        chk("done_blk_cnt", 128'(bus.blk_cnt_o), 128'(exp_done_q.pop_front()));
                        chk("done_after_all_words", 128'(exp_out_q.size()), 128'(0));
                    end
                end
                out_hold  = bus.out_valid_o && !out_fire && !bus.clear_i;
                hold_data = bus.out_data_o;
            end
        end
    end

    // driver tasks
    task automatic add_block(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3,
                             input logic [127:0] ct);
        src_q.push_back(w0);
        src_q.push_back(w1);
        src_q.push_back(w2);
        src_q.push_back(w3);
        exp_pt_q.push_back({w3, w2, w1, w0});
        ct_src_q.push_back(ct);
        exp_out_q.push_back(ct[31:0]);
        exp_out_q.push_back(ct[63:32]);
        exp_out_q.push_back(ct[95:64]);
        exp_out_q.push_back(ct[127:96]);
    endtask

    task automatic pulse_start(input logic [15:0] n);
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.nblocks_i = n;
        @(posedge clk); #1;
        bus.start_i   = 1'b0;
    endtask

    function automatic bit reached(input int which, input int target);
        case (which)
            0: return in_cnt >= target;
            1: return out_cnt >= target;
            2: return done_cnt >= target;
            default: return bus.dbg_state == S_WAIT;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input string name);
        int n;
        n = 0;
        while (!reached(which, target) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) fail_msg(name);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_state"}, 128'(bus.dbg_state), 128'(S_IDLE));
        chk({tag, "_busy"}, 128'(bus.busy_o), 128'(0));
        chk({tag, "_done"}, 128'(bus.done_o), 128'(0));
        chk({tag, "_in_ready"}, 128'(bus.in_ready_o), 128'(0));
        chk({tag, "_core_valid"}, 128'(bus.core_valid_o), 128'(0));
        chk({tag, "_ct_ready"}, 128'(bus.core_ct_ready_o), 128'(0));
        chk({tag, "_out_valid"}, 128'(bus.out_valid_o), 128'(0));
        chk({tag, "_core_pt"}, bus.core_pt_o, 128'(0));
        chk({tag, "_out_data"}, 128'(bus.out_data_o), 128'(0));
        chk({tag, "_blk_cnt"}, 128'(bus.blk_cnt_o), 128'(0));
    endtask

    task automatic add_three();
        add_block(32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003,
                  128'h13131313_12121212_11111111_10101010);
        add_block(32'hA1000000, 32'hA1000001, 32'hA1000002, 32'hA1000003,
                  128'h23232323_22222222_21212121_20202020);
        add_block(32'hA2000000, 32'hA2000001, 32'hA2000002, 32'hA2000003,
                  128'h33333333_32323232_31313131_30303030);
    endtask

    task automatic add_single();
        add_block(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C,
                  128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    endtask

    // main sequence
    initial begin
        int d0, base;
        reset_n       = 1'b0;
        bus.clear_i   = 1'b0;
        bus.enable_i  = 1'b1;
        bus.start_i   = 1'b0;
        bus.nblocks_i = '0;

        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // single block
        add_single();
        exp_done_q.push_back(16'd1);
        d0 = done_cnt;
        pulse_start(16'd1);
        wait_for(2, d0 + 1, "single_done_timeout");
        @(negedge clk);
        chk("single_blk_cnt_hold", 128'(bus.blk_cnt_o), 128'(1));
        chk("single_busy_after", 128'(bus.busy_o), 128'(0));

        // three blocks, random backpressure
        rand_bp = 1;
        add_three();
        exp_done_q.push_back(16'd3);
        d0 = done_cnt;
        pulse_start(16'd3);
        wait_for(2, d0 + 1, "three_done_timeout");
        rand_bp = 0;
        @(negedge clk);
        chk("three_blk_cnt_hold", 128'(bus.blk_cnt_o), 128'(3));

        // nblocks = 0
        base = out_cnt + in_cnt;
        exp_done_q.push_back(16'd0);
        @(posedge clk); #1;
        bus.start_i   = 1'b1;
        bus.nblocks_i = 16'd0;
        @(negedge clk);
        chk("zero_done_before_edge", 128'(bus.done_o), 128'(0));
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        chk("zero_done_pulse", 128'(bus.done_o), 128'(1));
        chk("zero_state_done", 128'(bus.dbg_state), 128'(S_DONE));
        chk("zero_blk_cnt", 128'(bus.blk_cnt_o), 128'(0));
        @(negedge clk);
        chk("zero_done_one_cycle", 128'(bus.done_o), 128'(0));
        chk("zero_busy_back", 128'(bus.busy_o), 128'(0));
        chk("zero_no_stream", 128'(out_cnt + in_cnt), 128'(base));

        // enable freeze mid-LOAD and mid-DRAIN
        add_single();
        exp_done_q.push_back(16'd1);
        d0 = done_cnt;
        base = in_cnt;
        pulse_start(16'd1);
        wait_for(0, base + 2, "en_load_timeout");
        bus.enable_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_load_in_ready", 128'(bus.in_ready_o), 128'(0));
            chk("en_load_state", 128'(bus.dbg_state), 128'(S_LOAD));
        end
        chk("en_load_in_cnt", 128'(in_cnt), 128'(base + 2));
        @(posedge clk); #1;
        bus.enable_i = 1'b1;
        base = out_cnt;
        wait_for(1, base + 2, "en_drain_timeout");
        bus.enable_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("en_drain_state", 128'(bus.dbg_state), 128'(S_DRAIN));
        end
        chk("en_drain_out_cnt", 128'(out_cnt), 128'(base + 2));
        @(posedge clk); #1;
        bus.enable_i = 1'b1;
        wait_for(2, d0 + 1, "en_done_timeout");

        // clear during block 2 drain
        add_three();
        base = out_cnt;
        d0 = done_cnt;
        pulse_start(16'd3);
        wait_for(1, base + 6, "clear_wait_timeout");
        bus.clear_i = 1'b1;
        @(posedge clk); #1;
        bus.clear_i = 1'b0;
        flush = 1;
        exp_pt_q.delete();
        exp_out_q.delete();
        ct_src_q.delete();
        @(negedge clk);
        check_idle_zero("clear");
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 0;
        chk("clear_no_done", 128'(done_cnt), 128'(d0));
        add_single();
        exp_done_q.push_back(16'd1);
        pulse_start(16'd1);
        wait_for(2, d0 + 1, "after_clear_timeout");

        // start while in WAIT is ignored
        core_lat = 6;
        add_single();
        add_block(32'h44444440, 32'h44444441, 32'h44444442, 32'h44444443,
                  128'h77777777_66666666_55555555_44444444);
        exp_done_q.push_back(16'd2);
        d0 = done_cnt;
        pulse_start(16'd2);
        wait_for(3, 0, "wait_state_timeout");
        pulse_start(16'd5);
        wait_for(2, d0 + 1, "wait_job_timeout");
        @(negedge clk);
        chk("wait_blk_cnt_hold", 128'(bus.blk_cnt_o), 128'(2));
        repeat (20) @(negedge clk);
        chk("wait_single_done", 128'(done_cnt), 128'(d0 + 1));

        chk("left_pt", 128'(exp_pt_q.size()), 128'(0));
        chk("left_out", 128'(exp_out_q.size()), 128'(0));
        chk("left_done", 128'(exp_done_q.size()), 128'(0));
        chk("left_ct", 128'(ct_src_q.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
